axis_frame_packetizer: RTL

Downstream stage for the `axis_counter` test source, or for any free-running AXI4-Stream sample source. It accepts an untyped sample stream and slices it into frames of a run-time configurable length, asserting `tlast` on each final beat so that DMA and RAM-writer stages can operate on frame boundaries. It also exports a frame counter for status registers and, optionally, checks that the input stream is gap-free.

---
 rtl/axis_frame_pkg.sv | 16 +
 rtl/axis_frame_packetizer_if.sv | 18 +
 rtl/axis_skid_buffer.sv | 87 ++++++++
 rtl/axis_frame_packetizer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/axis_frame_pkg.sv
// Shared definitions for the AXI4-Stream frame packetizer.
//   state_e           : packetizer FSM states
//   FRAME_COUNT_WIDTH : width of the completed-frame counter
//   SKID_DEPTH        : number of entries in the output skid buffer
package axis_frame_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StFinish = 2'd2
  } state_e;

  localparam int unsigned FRAME_COUNT_WIDTH = 32;
  localparam int unsigned SKID_DEPTH        = 2;

endpackage

// File: rtl/axis_frame_packetizer_if.sv
// AXI4-Stream bundle (tvalid/tready/tdata/tlast).
//   master modport : drives tvalid, tdata, tlast; receives tready
//   slave modport  : receives tvalid, tdata, tlast; drives tready
interface axis_frame_packetizer_if
  import axis_frame_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = 32
) ();

  logic                        tvalid;
  logic                        tready;
  logic [AXIS_TDATA_WIDTH-1:0] tdata;
  logic                        tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);

endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI4-Stream register slice carrying data + tlast, registered ready.
//   aclk, aresetn : clock, asynchronous active-low reset
//   i_en          : allow new beats in (ready is forced low when clear)
//   i_valid/i_data/i_last/o_ready : upstream side
//   m             : downstream AXI4-Stream master; outputs always come from entry 0
module axis_skid_buffer
  import axis_frame_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        i_en,
  input  logic                        i_valid,
  input  logic [AXIS_TDATA_WIDTH-1:0] i_data,
  input  logic                        i_last,
  output logic                        o_ready,
  axis_frame_packetizer_if.master     m
);

  localparam int unsigned CntW = $clog2(SKID_DEPTH + 1);

  logic [CntW-1:0]             r_count, w_count_d;
  logic [AXIS_TDATA_WIDTH-1:0] r_data0, r_data1, w_data0_d, w_data1_d;
  logic                        r_last0, r_last1, w_last0_d, w_last1_d;
  logic                        r_ready, w_ready_d;
  logic                        w_push, w_pop;

  assign w_push = i_valid & r_ready;
  assign w_pop  = (r_count != '0) & m.tready;

  always_comb begin
    w_count_d = r_count;
    w_data0_d = r_data0;
    w_data1_d = r_data1;
    w_last0_d = r_last0;
    w_last1_d = r_last1;
    unique case ({w_push, w_pop})
      2'b10: begin
        if (r_count == '0) begin
          w_data0_d = i_data;
          w_last0_d = i_last;
        end else begin
          w_data1_d = i_data;
          w_last1_d = i_last;
        end
        w_count_d = r_count + 1'b1;
      end
      2'b01: begin
        w_data0_d = r_data1;
        w_last0_d = r_last1;
        w_count_d = r_count - 1'b1;
      end
      // Push with pop only happens at one entry (ready is low when full).
      2'b11: begin
        w_data0_d = i_data;
        w_last0_d = i_last;
      end
      default: ;
    endcase
    w_ready_d = i_en && (w_count_d < CntW'(SKID_DEPTH));
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_count <= '0;
      r_data0 <= '0;
      r_data1 <= '0;
      r_last0 <= 1'b0;
      r_last1 <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_count <= w_count_d;
      r_data0 <= w_data0_d;
      r_data1 <= w_data1_d;
      r_last0 <= w_last0_d;
      r_last1 <= w_last1_d;
      r_ready <= w_ready_d;
    end
  end

  assign o_ready  = r_ready;
  assign m.tvalid = (r_count != '0);
  assign m.tdata  = r_data0;
  assign m.tlast  = r_last0;

endmodule

// File: rtl/axis_frame_packetizer.sv
// Slices a free-running AXI4-Stream sample stream into frames of cfg_length+1
// beats, marking the final beat of each frame with tlast.
//   aclk, aresetn : clock, asynchronous active-low reset
//   cfg_length    : frame length minus one, latched at frame start
//   enable        : frame generation enable; a falling enable finishes the frame
//   frame_count   : completed frames (tlast handshakes downstream), wraps
//   gap_error     : sticky input discontinuity flag
//   s_axis        : sample input (tlast ignored)
//   m_axis        : framed output
// Optional: define PACKETIZER_GAP_CHECK_EN to build the input continuity checker.
module axis_frame_packetizer
  import axis_frame_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned LENGTH_WIDTH     = 16
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [LENGTH_WIDTH-1:0]      cfg_length,
  input  logic                         enable,
  output logic [FRAME_COUNT_WIDTH-1:0] frame_count,
  output logic                         gap_error,
  axis_frame_packetizer_if.slave       s_axis,
  axis_frame_packetizer_if.master      m_axis
);

  state_e                         r_state, w_state_d;
  logic [LENGTH_WIDTH-1:0]        r_len, w_len_d;
  logic [LENGTH_WIDTH-1:0]        r_beat, w_beat_d;
  logic [FRAME_COUNT_WIDTH-1:0]   r_frame_count;
  logic                           w_s_ready, w_s_fire, w_last, w_en;

  assign w_s_fire = s_axis.tvalid & w_s_ready;
  assign w_last   = (r_beat == r_len);

  always_comb begin
    w_state_d = r_state;
    w_len_d   = r_len;
    w_beat_d  = r_beat;
    unique case (r_state)
      StIdle: begin
        w_beat_d = '0;
        if (enable) begin
          w_state_d = StRun;
          w_len_d   = cfg_length;
        end
      end
      StRun, StFinish: begin
        if (r_state == StRun && !enable) w_state_d = StFinish;
        if (w_s_fire) begin
          if (w_last) begin
            w_beat_d = '0;
            w_len_d  = cfg_length;
            if (r_state == StFinish || !enable) w_state_d = StIdle;
          end else begin
            w_beat_d = r_beat + 1'b1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= StIdle;
      r_len   <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_d;
      r_len   <= w_len_d;
      r_beat  <= w_beat_d;
    end
  end

  // Ready stays low on the entry cycle into RUN and drops on the exit beat.
  assign w_en = (r_state != StIdle) && (w_state_d != StIdle);

  axis_skid_buffer #(
    .AXIS_TDATA_WIDTH(AXIS_TDATA_WIDTH)
  ) u_skid (
    .aclk   (aclk),
    .aresetn(aresetn),
    .i_en   (w_en),
    .i_valid(s_axis.tvalid),
    .i_data (s_axis.tdata),
    .i_last (w_last),
    .o_ready(w_s_ready),
    .m      (m_axis)
  );

  assign s_axis.tready = w_s_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_frame_count <= '0;
    end else if (m_axis.tvalid && m_axis.tready && m_axis.tlast) begin
      r_frame_count <= r_frame_count + 1'b1;
    end
  end

  assign frame_count = r_frame_count;

`ifdef PACKETIZER_GAP_CHECK_EN
  logic [AXIS_TDATA_WIDTH-1:0] r_prev;
  logic                        r_first;
  logic                        r_gap;

  // The first beat after leaving IDLE has no predecessor to compare with.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_prev  <= '0;
      r_first <= 1'b1;
      r_gap   <= 1'b0;
    end else if (r_state == StIdle) begin
      r_first <= 1'b1;
      if (enable) r_gap <= 1'b0;
    end else if (w_s_fire) begin
      r_prev  <= s_axis.tdata;
      r_first <= 1'b0;
      if (!r_first && (s_axis.tdata != r_prev + 1'b1)) r_gap <= 1'b1;
    end
  end

  assign gap_error = r_gap;
`else
  assign gap_error = 1'b0;
`endif

endmodule
